alu_scheduler: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu.sv | 49 ++++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/alu_scheduler.sv | 119 +++++++++++
 tb/tb_alu_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and the request payload.
// Imported by the ALU, the arbiter wrapper and the scheduler top.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        cin;
    logic        usecc;
    logic        setcc;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU with SPARC-style carry/borrow and {N,Z,V,C} flags.
// SUB computes a - b - cin; C is the borrow out.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic [3:0]  opcode,
  output logic [31:0] y,
  output logic [3:0]  flags
);

  logic [32:0] sum;
  logic        v;
  logic        c;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sum   = '0;
    y     = a;
    v     = 1'b0;
    c     = 1'b0;
    flags = '0;
    case (opcode)
      ALU_ADD: begin
        sum = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        y   = sum[31:0];
        c   = sum[32];
        v   = (a[31] == b[31]) && (y[31] != a[31]);
      end
      ALU_SUB: begin
        sum = {1'b0, a} - {1'b0, b} - {32'b0, cin};
        y   = sum[31:0];
        c   = sum[32];
        v   = (a[31] != b[31]) && (y[31] != a[31]);
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = a;
    endcase
    flags[FLAG_N] = y[31];
    flags[FLAG_Z] = (y == 32'd0);
    flags[FLAG_V] = v;
    flags[FLAG_C] = c;
  end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; 'last' names the most recent winner and
// only moves on a real grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       grant_en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)         last <= 1'b1;
    else if (grant[0]) last <= 1'b0;
    else if (grant[1]) last <= 1'b1;
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU between two requesters through an execute (E) and result (W)
// register pair with back-pressure; owns the icc condition codes.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter logic [3:0] ICC_RESET = 4'b0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  input  logic [1:0][3:0] req_op,
  input  logic [1:0]      req_cin,
  input  logic [1:0]      req_usecc,
  input  logic [1:0]      req_setcc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [31:0]     rsp_y,
  output logic [3:0]      rsp_flags,
  output logic [3:0]      icc
);

  alu_req_t    e_req;
  alu_req_t    req_sel;
  logic        e_valid;
  logic        e_id;
  logic        w_valid;
  logic        w_id;
  logic [31:0] w_y;
  logic [3:0]  w_flags;
  logic [3:0]  icc_q;

  logic        w_free;
  logic        e_adv;
  logic        e_free;
  logic [1:0]  grant;
  logic        sel;
  logic        alu_cin;
  logic [31:0] alu_y;
  logic [3:0]  alu_flags;

  assign w_free = !w_valid || rsp_ready;
  assign e_adv  = e_valid && w_free;
  assign e_free = !e_valid || e_adv;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .grant_en (e_free && !reset),
    .req      (req_valid),
    .grant    (grant)
  );

  assign req_ready = grant;
  assign sel       = grant[1];

  always_comb begin
    req_sel = '{a:     req_a[sel],
                b:     req_b[sel],
                op:    req_op[sel],
                cin:   req_cin[sel],
                usecc: req_usecc[sel],
                setcc: req_setcc[sel]};
  end

  // Carry-in is resolved while the op sits in E; any earlier set-cc op has already written icc.
  assign alu_cin = e_req.usecc ? icc_q[FLAG_C] : e_req.cin;

  alu u_alu (
    .a      (e_req.a),
    .b      (e_req.b),
    .cin    (alu_cin),
    .opcode (e_req.op),
    .y      (alu_y),
    .flags  (alu_flags)
  );

  // NOTE: the E payload is not reset; e_valid alone qualifies it, so no reset mux is spent on data.
  always_ff @(posedge clk) begin
    if (|grant) begin
      e_req <= req_sel;
      e_id  <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= 1'b0;
      w_valid <= 1'b0;
      w_y     <= '0;
      w_flags <= '0;
      w_id    <= 1'b0;
      icc_q   <= ICC_RESET;
    end else begin
      if (e_adv) begin
        w_valid <= 1'b1;
        w_y     <= alu_y;
        w_flags <= alu_flags;
        w_id    <= e_id;
        if (e_req.setcc) icc_q <= alu_flags;
      end else if (w_valid && rsp_ready) begin
        w_valid <= 1'b0;
      end

      if (|grant)     e_valid <= 1'b1;
      else if (e_adv) e_valid <= 1'b0;
    end
  end

  assign rsp_valid = w_valid;
  assign rsp_id    = w_id;
  assign rsp_y     = w_y;
  assign rsp_flags = w_flags;
  assign icc       = icc_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: a sequential reference model predicts
// each accepted op's result and icc; a negedge monitor compares responses.
module tb_alu_scheduler;
  import alu_pkg::*;

  localparam logic [3:0] ICC_RESET = 4'b0000;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][3:0]  req_op;
  logic [1:0]       req_cin;
  logic [1:0]       req_usecc;
  logic [1:0]       req_setcc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_y;
  logic [3:0]       rsp_flags;
  logic [3:0]       icc;

  alu_scheduler #(.ICC_RESET(ICC_RESET)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_cin   (req_cin),
    .req_usecc (req_usecc),
    .req_setcc (req_setcc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_flags (rsp_flags),
    .icc       (icc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] y;
    logic [3:0]  flags;
    logic [3:0]  icc;
  } exp_t;

  alu_req_t pend[2][$];
  exp_t     sb[$];
  exp_t     rlog[$];
  logic [3:0] icc_m;
  logic       last_m;
  bit         acc[2];
  bit         rnd;
  int         total;
  int         bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: ops execute in acceptance order, each seeing the icc left by all earlier ones.
  function automatic exp_t predict(input alu_req_t r, input logic id);
    exp_t        e;
    longint      ua, ub, sa, sb_v, cl, res, sres;
    logic [31:0] y;
    logic        c, v;
    ua = r.a;
    ub = r.b;
    sa = longint'($signed(r.a));
    sb_v = longint'($signed(r.b));
    cl = (r.usecc ? icc_m[0] : r.cin) ? 1 : 0;
    c = 1'b0;
    v = 1'b0;
    res = 0;
    case (r.op)
      ALU_ADD: begin
        res  = ua + ub + cl;
        sres = sa + sb_v + cl;
        c = (res > 64'sd4294967295);
        v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      ALU_SUB: begin
        res  = ua - ub - cl;
        sres = sa - sb_v - cl;
        c = (res < 0);
        v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      ALU_AND: res = ua & ub;
      ALU_OR:  res = ua | ub;
      ALU_XOR: res = ua ^ ub;
      default: res = ua;
    endcase
    y = res[31:0];
    e.id    = id;
    e.y     = y;
    e.flags = {y[31], (y == 32'd0), v, c};
    if (r.setcc) icc_m = e.flags;
    e.icc = icc_m;
    return e;
  endfunction

  always @(negedge clk) begin
    int occ;
    exp_t e;
    if (reset) begin
      check("ready_in_reset", req_ready, 2'b00);
      sb.delete();
      icc_m  = ICC_RESET;
      last_m = 1'b1;
      acc[0] = 0;
      acc[1] = 0;
    end else begin
      occ = sb.size();
      check("ready_onehot", (req_ready == 2'b11), 0);
      check("ready_any", |req_ready, (|req_valid) && (occ < 2 || rsp_ready));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sb[0];
          check("rsp_id", rsp_id, e.id);
          check("rsp_y", rsp_y, e.y);
          check("rsp_flags", rsp_flags, e.flags);
          check("rsp_icc", icc, e.icc);
          if (rsp_ready) begin
            rlog.push_back(e);
            void'(sb.pop_front());
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (pend[i].size() == 0) begin
            check("accept_no_op", req_ready[i], 0);
          end else begin
            if (req_valid == 2'b11) check("tie_winner", i, last_m ? 0 : 1);
            last_m = i[0];
            sb.push_back(predict(pend[i][0], i[0]));
            acc[i] = 1;
          end
        end
      end
    end
  end

  // Drivers present the head of each pending queue and retire it once accepted.
  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    req_cin = '0; req_usecc = '0; req_setcc = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          void'(pend[i].pop_front());
          acc[i] = 0;
        end
        if (pend[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_a[i]     = pend[i][0].a;
          req_b[i]     = pend[i][0].b;
          req_op[i]    = pend[i][0].op;
          req_cin[i]   = pend[i][0].cin;
          req_usecc[i] = pend[i][0].usecc;
          req_setcc[i] = pend[i][0].setcc;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd) rsp_ready = ($urandom_range(3) != 0);
  end

  function automatic alu_req_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                  input logic cin, input logic usecc, input logic setcc);
    alu_req_t r;
    r = '{a: a, b: b, op: op, cin: cin, usecc: usecc, setcc: setcc};
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  function automatic alu_req_t rand_req();
    logic [3:0] op;
    case ($urandom_range(4))
      0: op = ALU_ADD;
      1: op = ALU_SUB;
      2: op = ALU_AND;
      3: op = ALU_OR;
      default: op = ALU_XOR;
    endcase
    return mk(rand_word(), rand_word(), op, 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'($urandom_range(1)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend[0].size() != 0 || pend[1].size() != 0 || sb.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", pend[0].size() + pend[1].size() + sb.size(), 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    total = 0; bad = 0; rnd = 0;
    icc_m = ICC_RESET; last_m = 1'b1;
    reset = 1'b1; rsp_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_icc", icc, ICC_RESET);
    check("reset_rsp_y", rsp_y, 0);
    check("reset_rsp_flags", rsp_flags, 0);
    check("reset_rsp_id", rsp_id, 0);

    // Single add with set-cc and the two-edge latency
    tick();
    pend[0].push_back(mk(32'h7FFF_FFFF, 32'd1, ALU_ADD, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    @(negedge clk);
    check("t1_accept", req_ready[0], 1);
    @(negedge clk);
    check("t1_not_yet", rsp_valid, 0);
    @(negedge clk);
    check("t1_valid", rsp_valid, 1);
    check("t1_y", rsp_y, 32'h8000_0000);
    check("t1_flags", rsp_flags, 4'b1010);
    check("t1_icc", icc, 4'b1010);
    check("t1_id", rsp_id, 0);
    drain(50);

    // Carry chain on requester 1
    rlog.delete();
    pend[1].push_back(mk(32'hFFFF_FFFF, 32'd1, ALU_ADD, 1'b0, 1'b0, 1'b1));
    pend[1].push_back(mk(32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b0));
    drain(50);
    check("t3_count", rlog.size(), 2);
    if (rlog.size() == 2) check("t3_y2", rlog[1].y, 32'd1);
    check("t3_icc", icc, 4'b0101);

    // Flags reported without set-cc
    rlog.delete();
    pend[1].push_back(mk(32'd5, 32'd5, ALU_SUB, 1'b0, 1'b0, 1'b0));
    drain(50);
    check("t6_count", rlog.size(), 1);
    if (rlog.size() == 1) begin
      check("t6_y", rlog[0].y, 32'd0);
      check("t6_flags", rlog[0].flags, 4'b0100);
    end
    check("t6_icc", icc, 4'b0101);

    // Tie arbitration
    rlog.delete();
    for (int k = 0; k < 2; k++) begin
      pend[0].push_back(mk($urandom(), $urandom(), ALU_ADD, 1'b0, 1'b0, 1'b0));
      pend[1].push_back(mk($urandom(), $urandom(), ALU_ADD, 1'b0, 1'b0, 1'b0));
    end
    drain(50);
    check("t2_count", rlog.size(), 4);
    for (int k = 0; k < rlog.size() && k < 4; k++) check("t2_id_seq", rlog[k].id, k % 2);

    // Back-pressure with three ops queued
    rsp_ready = 1'b0;
    pend[0].push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_ADD, 1'b0, 1'b0, 1'b1));
    pend[0].push_back(mk(32'd1, 32'd2, ALU_SUB, 1'b0, 1'b0, 1'b1));
    pend[1].push_back(mk(32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 1'b1));
    repeat (5) @(negedge clk);
    check("t4_ready_low", req_ready, 2'b00);
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_rsp_y", rsp_y, 32'hFFFF_FFFE);
    check("t4_rsp_id", rsp_id, 0);
    check("t4_icc", icc, 4'b1001);
    tick();
    rsp_ready = 1'b1;
    drain(50);
    check("t4_icc_final", icc, 4'b1001);

    // Reset with both stages full and a set-cc op waiting in E
    rsp_ready = 1'b0;
    pend[0].push_back(mk(32'h7FFF_FFFF, 32'd1, ALU_ADD, 1'b0, 1'b0, 1'b1));
    pend[1].push_back(mk(32'd0, 32'd1, ALU_SUB, 1'b0, 1'b0, 1'b1));
    pend[0].push_back(mk(32'd3, 32'd4, ALU_ADD, 1'b0, 1'b0, 1'b1));
    n = 0;
    while (sb.size() != 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_fill", sb.size(), 2);
    tick();
    reset = 1'b1;
    pend[0].delete();
    pend[1].delete();
    req_valid = 2'b00;
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_icc", icc, ICC_RESET);
    check("t5_rsp_y", rsp_y, 0);
    check("t5_rsp_flags", rsp_flags, 0);
    check("t5_rsp_id", rsp_id, 0);
    rlog.delete();
    pend[0].push_back(mk(32'd10, 32'd20, ALU_ADD, 1'b0, 1'b0, 1'b0));
    pend[1].push_back(mk(32'd30, 32'd40, ALU_ADD, 1'b0, 1'b0, 1'b0));
    drain(50);
    check("t5_count", rlog.size(), 2);
    if (rlog.size() != 0) check("t5_first_id", rlog[0].id, 0);

    // Randomized traffic with random back-pressure
    rnd = 1;
    for (int k = 0; k < 300; k++) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (pend[i].size() < 4 && $urandom_range(2) != 0) pend[i].push_back(rand_req());
    end
    drain(3000);
    rnd = 0;
    rsp_ready = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
